// File: rtl/darkriscv_dbus_bridge_if.sv
// Core data port and word-only memory bus bundle.
// master: the bridge; slave: the core and memory environment.
interface darkriscv_dbus_bridge_if;
    logic [31:0] core_daddr;
    logic [31:0] core_datao;
    logic [2:0]  core_dlen;
    logic        core_drd;
    logic        core_dwr;
    logic [31:0] core_datai;
    logic        core_hlt;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic        err_misaligned;
    logic        err_timeout;

    modport master (
        input  core_daddr, core_datao, core_dlen, core_drd, core_dwr,
        output core_datai, core_hlt,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_response,
        output err_misaligned, err_timeout
    );

    modport slave (
        output core_daddr, core_datao, core_dlen, core_drd, core_dwr,
        input  core_datai, core_hlt,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_response,
        input  err_misaligned, err_timeout
    );
endinterface

// File: rtl/darkriscv_dbus_bridge.sv
// darkriscv data port to word-only memory bus bridge.
// Sub-word stores are done as read-modify-write; the core is held via HLT.
module darkriscv_dbus_bridge #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input logic                     clk,
    input logic                     reset,
    darkriscv_dbus_bridge_if.master bus
);
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e        state_q, state_d;
    size_e         size_q, size_d, size_in;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   datai_q, datai_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mis_q, mis_d;
    logic          to_q, to_d;
    logic          req, misal, expired, hlt;
    logic [3:0]    mask;
    logic [31:0]   merged;

    assign req     = bus.core_drd | bus.core_dwr;
    assign expired = (cnt_q == CNT_LAST);

    always_comb begin
        unique case (bus.core_dlen)
            3'd1:    size_in = SZ_B;
            3'd2:    size_in = SZ_H;
            default: size_in = SZ_W;
        endcase
    end

    assign misal = ((size_in == SZ_H) && bus.core_daddr[0]) ||
                   ((size_in == SZ_W) && (bus.core_daddr[1:0] != 2'b00));

    // Store lanes come from the core, the rest from the word just read.
    always_comb begin
        unique case (size_q)
            SZ_B:    mask = 4'b0001 << addr_q[1:0];
            SZ_H:    mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask[i] ? data_q[8*i +: 8]
                                       : bus.mem_read_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        datai_d = datai_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        to_d    = to_q;
        hlt     = 1'b1;
        unique case (state_q)
            IDLE: begin
                hlt = req;
                if (req) begin
                    addr_d = bus.core_daddr;
                    data_d = bus.core_datao;
                    size_d = size_in;
                    cnt_d  = '0;
                    if (misal) begin
                        mis_d   = 1'b1;
                        datai_d = '0;
                        state_d = DONE;
                    end else if (!bus.core_dwr) begin
                        state_d = RD;
                    end else if (size_in == SZ_W) begin
                        wdata_d = bus.core_datao;
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                if (bus.mem_response) begin
                    datai_d = bus.mem_read_data;
                    state_d = DONE;
                end else if (expired) begin
                    to_d    = 1'b1;
                    datai_d = TIMEOUT_DATA;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RMW_RD: begin
                if (bus.mem_response) begin
                    wdata_d = merged;
                    cnt_d   = '0;
                    state_d = WR;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (bus.mem_response) begin
                    state_d = DONE;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                hlt     = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            size_q  <= SZ_B;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            datai_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            datai_q <= datai_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // HLT is combinational from the request, so mask it while in reset.
    assign bus.core_hlt       = reset & hlt;
    assign bus.core_datai     = datai_q;
    assign bus.mem_read       = (state_q == RD) || (state_q == RMW_RD);
    assign bus.mem_write      = (state_q == WR);
    assign bus.mem_address    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_data = wdata_q;
    assign bus.err_misaligned = mis_q;
    assign bus.err_timeout    = to_q;
endmodule

// File: tb/tb_darkriscv_dbus_bridge.sv
// Bench for darkriscv_dbus_bridge: transaction-level timeline model,
// per-cycle compare process, directed cases and random traffic.
module tb_darkriscv_dbus_bridge;
    localparam int          TO    = 8;
    localparam logic [31:0] TDATA = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset;

    darkriscv_dbus_bridge_if bus();

    darkriscv_dbus_bridge #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_DATA  (TDATA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic        exp_hlt, exp_rd, exp_wr, exp_dv, exp_mis, exp_to;
    logic [31:0] exp_addr, exp_wdata, exp_datai;
    logic [31:0] mem [logic [31:0]];
    int          n_rd, n_wr, done_at;
    logic [31:0] last_datai;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hlt", {31'd0, bus.core_hlt}, {31'd0, exp_hlt});
            chk("mem_read", {31'd0, bus.mem_read}, {31'd0, exp_rd});
            chk("mem_write", {31'd0, bus.mem_write}, {31'd0, exp_wr});
            if (exp_rd || exp_wr)
                chk("mem_address", bus.mem_address, exp_addr);
            if (exp_wr)
                chk("mem_write_data", bus.mem_write_data, exp_wdata);
            if (exp_dv)
                chk("core_datai", bus.core_datai, exp_datai);
            chk("err_mis", {31'd0, bus.err_misaligned}, {31'd0, exp_mis});
            chk("err_to", {31'd0, bus.err_timeout}, {31'd0, exp_to});
        end
    end

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic garbage();
        bus.core_daddr = $urandom;
        bus.core_datao = $urandom;
        bus.core_dlen  = 3'($urandom);
        bus.core_drd   = 1'($urandom);
        bus.core_dwr   = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            garbage();
            bus.core_drd      = 1'b0;
            bus.core_dwr      = 1'b0;
            bus.mem_response  = 1'($urandom);
            bus.mem_read_data = $urandom;
            exp_hlt = 1'b0;
            exp_rd  = 1'b0;
            exp_wr  = 1'b0;
            exp_dv  = 1'b0;
            chk_en  = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // kr/kw: wait cycles before the memory answers each phase.
    task automatic txn(input logic [31:0] a, input logic [2:0] dl,
                       input bit rd, input bit wr, input logic [31:0] d,
                       input int kr, input int kw);
        int          sz, lo, rs, re, ws, we, dn;
        bit          mis, rto, wto;
        logic [31:0] wa, old, mrg, rdv;
        sz  = (dl == 3'd1) ? 1 : (dl == 3'd2) ? 2 : 4;
        lo  = int'(a[1:0]);
        mis = (sz == 2 && a[0]) || (sz == 4 && lo != 0);
        wa  = {a[31:2], 2'b00};
        old = mem_get(wa);
        mrg = old;
        for (int l = 0; l < 4; l++)
            if (l >= lo && l < lo + sz) mrg[8*l +: 8] = d[8*l +: 8];
        rs = -1; re = -2; ws = -1; we = -2;
        rto = 1'b0; wto = 1'b0;
        if (mis) begin
            dn = 1;
        end else if (wr && sz == 4) begin
            ws = 1;
            if (kw < TO) we = 1 + kw;
            else begin we = TO; wto = 1'b1; end
            dn = we + 1;
        end else begin
            rs = 1;
            if (kr < TO) re = 1 + kr;
            else begin re = TO; rto = 1'b1; end
            if (wr && !rto) begin
                ws = re + 1;
                if (kw < TO) we = ws + kw;
                else begin we = ws + TO - 1; wto = 1'b1; end
                dn = we + 1;
            end else begin
                dn = re + 1;
            end
        end
        rdv = mis ? 32'h0 : rto ? TDATA : old;
        n_rd = 0; n_wr = 0; done_at = -1;
        for (int j = 0; j <= dn; j++) begin
            if (j == 0) begin
                bus.core_daddr = a;
                bus.core_datao = d;
                bus.core_dlen  = dl;
                bus.core_drd   = rd;
                bus.core_dwr   = wr;
            end else begin
                garbage();
            end
            if (j >= 1 && j < dn)
                bus.mem_response = (j == re && !rto) || (j == we && !wto);
            else
                bus.mem_response = 1'($urandom);
            bus.mem_read_data = (j == re) ? old : $urandom;
            exp_rd    = (j >= rs && j <= re);
            exp_wr    = (j >= ws && j <= we);
            exp_hlt   = (j < dn);
            exp_addr  = wa;
            exp_wdata = mrg;
            exp_dv    = (j == dn) && rd && !wr;
            exp_datai = rdv;
            if (j >= 1 && mis) exp_mis = 1'b1;
            if (j == dn && (rto || wto)) exp_to = 1'b1;
            chk_en = 1'b1;
            @(negedge clk);
            n_rd += int'(bus.mem_read);
            n_wr += int'(bus.mem_write);
            if (!bus.core_hlt && done_at < 0) done_at = j;
            if (j == dn) last_datai = bus.core_datai;
            if (j == we && !wto) mem[wa] = bus.mem_write_data;
            @(posedge clk);
            #1;
        end
    endtask

    logic [2:0]  dls [6] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd7};

    initial begin
        logic [31:0] ra, rb, rdat;
        logic [2:0]  rdl;
        logic [1:0]  rw;
        int          rkr, rkw;

        reset = 1'b0;
        bus.core_daddr = '0;
        bus.core_datao = '0;
        bus.core_dlen  = '0;
        bus.core_drd   = 1'b0;
        bus.core_dwr   = 1'b0;
        bus.mem_read_data = '0;
        bus.mem_response  = 1'b0;
        exp_hlt = 0; exp_rd = 0; exp_wr = 0; exp_dv = 0;
        exp_mis = 0; exp_to = 0;
        exp_addr = '0; exp_wdata = '0; exp_datai = '0;
        #12;
        chk("rst_hlt", {31'd0, bus.core_hlt}, 32'd0);
        chk("rst_rd", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_wr", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);
        chk("rst_datai", bus.core_datai, 32'd0);
        chk("rst_err", {30'd0, bus.err_misaligned, bus.err_timeout}, 32'd0);
        bus.core_drd = 1'b1;
        #1;
        chk("rst_hlt_req", {31'd0, bus.core_hlt}, 32'd0);
        bus.core_drd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        mem[32'h100] = 32'h12345678;
        txn(32'h100, 3'd4, 1, 0, 32'h0, 2, 0);
        chk("t1_nrd", n_rd, 3);
        chk("t1_datai", last_datai, 32'h12345678);
        chk("t1_rel", done_at, 4);

        mem[32'h200] = 32'h11223344;
        txn(32'h203, 3'd1, 0, 1, 32'hABABABAB, 1, 2);
        chk("t2_mem", mem[32'h200], 32'hAB223344);
        chk("t2_nrd", n_rd, 2);
        chk("t2_nwr", n_wr, 3);
        chk("t2_rel", done_at, 6);

        mem[32'h300] = 32'h0;
        txn(32'h302, 3'd2, 0, 1, 32'hBEEFBEEF, 0, 0);
        chk("t3_mem", mem[32'h300], 32'hBEEF0000);
        txn(32'h304, 3'd4, 0, 1, 32'hCAFEF00D, 0, 0);
        chk("t4_nrd", n_rd, 0);
        chk("t4_nwr", n_wr, 1);
        chk("t4_mem", mem[32'h304], 32'hCAFEF00D);
        idle(1);

        txn(32'h101, 3'd2, 1, 0, 32'h0, 0, 0);
        chk("t5_mis", {31'd0, bus.err_misaligned}, 32'd1);
        chk("t5_nacc", n_rd + n_wr, 0);
        chk("t5_datai", last_datai, 32'h0);
        chk("t5_rel", done_at, 1);

        txn(32'h500, 3'd4, 1, 0, 32'h0, 20, 0);
        chk("t6_nrd", n_rd, 8);
        chk("t6_to", {31'd0, bus.err_timeout}, 32'd1);
        chk("t6_datai", last_datai, 32'hDEADBEEF);

        mem[32'h400] = 32'h55667788;
        chk_en = 1'b0;
        bus.core_daddr = 32'h401;
        bus.core_dlen  = 3'd1;
        bus.core_drd   = 1'b0;
        bus.core_dwr   = 1'b1;
        bus.core_datao = 32'h99999999;
        bus.mem_response = 1'b0;
        @(posedge clk);
        #1;
        chk("t7_rd_pre", {31'd0, bus.mem_read}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t7_rd", {31'd0, bus.mem_read}, 32'd0);
        chk("t7_hlt", {31'd0, bus.core_hlt}, 32'd0);
        chk("t7_err", {30'd0, bus.err_misaligned, bus.err_timeout}, 32'd0);
        @(posedge clk);
        #1;
        bus.core_dwr = 1'b0;
        reset = 1'b1;
        exp_mis = 1'b0;
        exp_to  = 1'b0;
        txn(32'h400, 3'd4, 1, 0, 32'h0, 1, 0);
        chk("t7_datai", last_datai, 32'h55667788);
        chk("t7_mem", mem[32'h400], 32'h55667788);

        for (int i = 0; i < 300; i++) begin
            ra  = $urandom_range(0, 255);
            rdl = dls[$urandom_range(0, 5)];
            rw  = 2'($urandom_range(1, 3));
            rb  = $urandom;
            if (rdl == 3'd1) rdat = {4{rb[7:0]}};
            else if (rdl == 3'd2) rdat = {2{rb[15:0]}};
            else rdat = rb;
            rkr = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3)
                                               : $urandom_range(0, 5);
            rkw = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3)
                                               : $urandom_range(0, 5);
            txn(ra, rdl, rw[0], rw[1], rdat, rkr, rkw);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
